bus_arbiter: RTL and testbench

//  Sits directly upstream of the 8-bit tri-state data bus drivers. Grants bus ownership to
//  one of NUM_MASTERS requesters at a time and drives a one-hot enable vector, one bit

---
 rtl/bus_arbiter_if.sv | 31 +++
 rtl/bus_arbiter.sv | 127 ++++++++++++
 tb/tb_bus_arbiter.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bus_arbiter_if.sv
// Arbiter-side bus bundle: per-master requests in, one-hot driver enables and status out.
// The arbiter connects through the slave modport; requesters or a bench use the master modport.
interface bus_arbiter_if #(
    parameter int NUM_MASTERS = 4
);
    localparam int IW = $clog2(NUM_MASTERS);

    // req[i] stays high for the whole transfer of master i.
    // grant[i] enables the bus driver of master i and is never set for two masters at once.
    logic [NUM_MASTERS-1:0] req;
    logic [NUM_MASTERS-1:0] grant;
    logic                   busy;
    logic [IW-1:0]          owner_id;
    logic                   timeout_evt;

    modport slave (
        input  req,
        output grant,
        output busy,
        output owner_id,
        output timeout_evt
    );

    modport master (
        output req,
        input  grant,
        input  busy,
        input  owner_id,
        input  timeout_evt
    );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with guaranteed dead turnaround cycles between owners.
// Optional ownership timeout is enabled by defining BUS_ARB_TIMEOUT_EN.
module bus_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    bus_arbiter_if.slave bus,
    output logic [1:0]  state_dbg
);
    localparam int IW = $clog2(NUM_MASTERS);
    localparam int TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t                 state;
    logic [IW-1:0]          rr_ptr;
    logic [TW-1:0]          turn_cnt;
    logic                   found;
    logic [IW-1:0]          win;
    logic [NUM_MASTERS-1:0] win_onehot;
    logic [IW-1:0]          next_ptr;
    logic                   owner_req;
    int                     idx;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAX_HOLD);
    logic [HW-1:0] hold_cnt;
`endif

    // Search from rr_ptr upward, wrapping; the first requester found wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_MASTERS;
            if (!found && bus.req[idx]) begin
                found = 1'b1;
                win   = IW'(idx);
            end
        end
    end

    assign win_onehot = {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win;
    assign next_ptr   = (bus.owner_id == IW'(NUM_MASTERS - 1)) ? '0 : bus.owner_id + IW'(1);
    assign owner_req  = bus.req[bus.owner_id];
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            turn_cnt        <= '0;
            bus.grant       <= '0;
            bus.busy        <= 1'b0;
            bus.owner_id    <= '0;
            bus.timeout_evt <= 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
            hold_cnt        <= '0;
`endif
        end else begin
            bus.timeout_evt <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        bus.grant    <= win_onehot;
                        bus.busy     <= 1'b1;
                        bus.owner_id <= win;
                        state        <= GRANT;
`ifdef BUS_ARB_TIMEOUT_EN
                        hold_cnt     <= '0;
`endif
                    end
                end
                GRANT: begin
                    // A voluntary release wins over a timeout on the same edge.
                    if (!owner_req) begin
                        bus.grant <= '0;
                        bus.busy  <= 1'b0;
                        rr_ptr    <= next_ptr;
                        turn_cnt  <= TW'(TURN_CYCLES - 1);
                        state     <= TURN;
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    else if (hold_cnt == HW'(MAX_HOLD - 1)) begin
                        bus.grant       <= '0;
                        bus.busy        <= 1'b0;
                        bus.timeout_evt <= 1'b1;
                        rr_ptr          <= next_ptr;
                        turn_cnt        <= TW'(TURN_CYCLES - 1);
                        state           <= TURN;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
`endif
                end
                TURN: begin
                    if (turn_cnt != '0) begin
                        turn_cnt <= turn_cnt - TW'(1);
                    end else if (found) begin
                        bus.grant    <= win_onehot;
                        bus.busy     <= 1'b1;
                        bus.owner_id <= win;
                        state        <= GRANT;
`ifdef BUS_ARB_TIMEOUT_EN
                        hold_cnt     <= '0;
`endif
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    bus.grant <= '0;
                    bus.busy  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: four masters drive a shared tri-state 8-bit bus.
// Per-cycle monitor checks one-hot grant, busy consistency and the bus value.
module tb_bus_arbiter;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state_dbg;
    int         checks = 0;
    int         errors = 0;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_TURN  = 2'd2;

    bus_arbiter_if #(.NUM_MASTERS(N)) bif ();

    bus_arbiter #(.NUM_MASTERS(N), .TURN_CYCLES(1), .MAX_HOLD(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bif),
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    // Each master drives a distinct byte onto the shared bus when enabled.
    wire [7:0] data_bus;
    for (genvar g = 0; g < N; g++) begin : g_drv
        assign data_bus = bif.grant[g] ? 8'(8'h10 + g) : 8'bz;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        bif.req = '0;
        #2;
        chk("rst_grant", 32'(bif.grant), 32'h0);
        chk("rst_busy", 32'(bif.busy), 32'h0);
        chk("rst_owner", 32'(bif.owner_id), 32'h0);
        chk("rst_tmo", 32'(bif.timeout_evt), 32'h0);
        chk("rst_state", 32'(state_dbg), 32'(S_IDLE));
        rst_n = 1'b1;
        step(1);
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            checks++;
            assert ($countones(bif.grant) <= 1)
            else begin
                errors++;
                $error("FAIL onehot: observed %b expected at most one bit", bif.grant);
            end
            checks++;
            assert (bif.busy === (|bif.grant))
            else begin
                errors++;
                $error("FAIL busy_eq: observed %b expected %b", bif.busy, |bif.grant);
            end
            if (|bif.grant) begin
                checks++;
                assert (data_bus === 8'(16 + int'(bif.owner_id)))
                else begin
                    errors++;
                    $error("FAIL bus_net: observed %h expected %h", data_bus,
                           8'(16 + int'(bif.owner_id)));
                end
            end
        end
    end

    initial begin
        bif.req = '0;

        // Single request, then release.
        do_reset();
        bif.req = 4'b0100;
        step(1);
        chk("t1_grant", 32'(bif.grant), 32'h4);
        chk("t1_owner", 32'(bif.owner_id), 32'h2);
        chk("t1_busy", 32'(bif.busy), 32'h1);
        chk("t1_state", 32'(state_dbg), 32'(S_GRANT));
        bif.req = 4'b0000;
        step(1);
        chk("t1_rel_grant", 32'(bif.grant), 32'h0);
        chk("t1_rel_owner", 32'(bif.owner_id), 32'h2);
        step(1);
        chk("t1_idle", 32'(state_dbg), 32'(S_IDLE));

        // Full contention: round-robin order 0,1,2,3,0 with one dead cycle each.
        do_reset();
        bif.req = 4'b1111;
        step(1);
        for (int n = 0; n < 5; n++) begin
            int k;
            k = n % N;
            chk("t2_g1", 32'(bif.grant), 32'(1 << k));
            chk("t2_owner", 32'(bif.owner_id), 32'(k));
            step(1);
            chk("t2_g2", 32'(bif.grant), 32'(1 << k));
            step(1);
            chk("t2_g3", 32'(bif.grant), 32'(1 << k));
            bif.req[k] = 1'b0;
            step(1);
            chk("t2_dead", 32'(bif.grant), 32'h0);
            chk("t2_turn", 32'(state_dbg), 32'(S_TURN));
            bif.req[k] = 1'b1;
            step(1);
        end
        bif.req = '0;
        step(4);
        chk("t2_end", 32'(bif.grant), 32'h0);

        // Mid-transfer request from another master is ignored until release.
        do_reset();
        bif.req = 4'b0010;
        step(2);
        chk("t3_g", 32'(bif.grant), 32'h2);
        bif.req = 4'b1010;
        step(1);
        chk("t3_hold1", 32'(bif.grant), 32'h2);
        step(1);
        chk("t3_hold2", 32'(bif.grant), 32'h2);
        bif.req = 4'b1000;
        step(1);
        chk("t3_dead", 32'(bif.grant), 32'h0);
        step(1);
        chk("t3_next", 32'(bif.grant), 32'h8);
        chk("t3_owner", 32'(bif.owner_id), 32'h3);
        bif.req = 4'b0000;
        step(3);

        // Asynchronous reset mid-grant.
        do_reset();
        bif.req = 4'b0001;
        step(2);
        chk("t4_pre", 32'(bif.grant), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_async_grant", 32'(bif.grant), 32'h0);
        chk("t4_async_busy", 32'(bif.busy), 32'h0);
        bif.req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        step(3);
        chk("t4_after_grant", 32'(bif.grant), 32'h0);
        chk("t4_after_busy", 32'(bif.busy), 32'h0);
        chk("t4_after_owner", 32'(bif.owner_id), 32'h0);

`ifdef BUS_ARB_TIMEOUT_EN
        // Hold cap: 16 grant cycles, timeout pulse, one dead cycle, then master 1.
        do_reset();
        bif.req = 4'b0011;
        step(1);
        chk("t5_g0", 32'(bif.grant), 32'h1);
        for (int i = 1; i < 16; i++) begin
            step(1);
            chk("t5_hold", 32'(bif.grant), 32'h1);
            chk("t5_notmo", 32'(bif.timeout_evt), 32'h0);
        end
        step(1);
        chk("t5_revoke", 32'(bif.grant), 32'h0);
        chk("t5_tmo", 32'(bif.timeout_evt), 32'h1);
        step(1);
        chk("t5_next", 32'(bif.grant), 32'h2);
        chk("t5_tmo_clr", 32'(bif.timeout_evt), 32'h0);
        bif.req = '0;
        step(3);
`else
        // Without the timeout, ownership is unbounded and timeout_evt stays low.
        do_reset();
        bif.req = 4'b0011;
        step(1);
        for (int i = 0; i < 40; i++) begin
            chk("t5_unbounded", 32'(bif.grant), 32'h1);
            chk("t5_tmo_zero", 32'(bif.timeout_evt), 32'h0);
            step(1);
        end
        bif.req = 4'b0010;
        step(1);
        chk("t5_dead", 32'(bif.grant), 32'h0);
        step(1);
        chk("t5_next", 32'(bif.grant), 32'h2);
        bif.req = '0;
        step(3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
